// File: rtl/tdm_lane_demux.sv
// Receive-side TDM lane demultiplexer: collects one SOF-framed beat per lane into
// shadow registers and publishes the whole lane word atomically on frame completion.
module tdm_lane_demux #(
   parameter int W     = 2,
   parameter int LANES = 4,
   localparam int SW   = $clog2(LANES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [W-1:0]         in_data,
   output logic [LANES*W-1:0]   out_lanes,
   output logic                 out_valid,
   output logic                 err,
   output logic [SW-1:0]        slot,
   output logic [7:0]           frame_cnt
);

   localparam logic [SW-1:0] LAST = SW'(LANES - 1);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t                     state;
   logic [LANES-1:0][W-1:0]    shadow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         slot      <= '0;
         shadow    <= '0;
         out_lanes <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         out_valid <= 1'b0;
         err       <= 1'b0;
         if (in_valid) begin
            case (state)
               IDLE: begin
                  // Non-SOF beats in IDLE belong to no frame and are dropped.
                  if (in_sof) begin
                     shadow[0] <= in_data;
                     slot      <= SW'(1);
                     state     <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (in_sof) begin
                     // Early SOF: abandon the partial frame and resync on this beat.
                     err       <= 1'b1;
                     shadow[0] <= in_data;
                     slot      <= SW'(1);
                  end else begin
                     shadow[slot] <= in_data;
                     if (slot == LAST) begin
                        out_lanes <= {in_data, shadow[LANES-2:0]};
                        out_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                        slot      <= '0;
                        state     <= IDLE;
                     end else begin
                        slot <= slot + SW'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_lane_demux.sv
// Randomised and directed bench for tdm_lane_demux, checked against a frame-level model.
module tb_tdm_lane_demux;

   localparam int W = 2;
   localparam int LANES = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_sof = 1'b0;
   logic [W-1:0]     in_data = '0;
   logic [LANES*W-1:0] out_lanes;
   logic             out_valid;
   logic             err;
   logic [1:0]       slot;
   logic [7:0]       frame_cnt;

   int errors = 0;
   int checks = 0;

   tdm_lane_demux #(.W(W), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_lanes(out_lanes), .out_valid(out_valid), .err(err), .slot(slot),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: list of beats gathered for the current frame (-1 = no frame open).
   int               m_pos;
   logic [W-1:0]     m_beats [LANES];
   logic [7:0]       m_lanes;
   logic [7:0]       m_cnt;
   logic             exp_valid, exp_err;
   logic [1:0]       exp_slot;

   task automatic model_reset();
      m_pos = -1; m_lanes = '0; m_cnt = '0; exp_valid = 0; exp_err = 0; exp_slot = '0;
   endtask

   task automatic model_beat(input logic v, input logic s, input logic [W-1:0] d);
      exp_valid = 0; exp_err = 0;
      if (v) begin
         if (s) begin
            if (m_pos >= 0) exp_err = 1;
            m_beats[0] = d;
            m_pos = 1;
         end else if (m_pos >= 0) begin
            m_beats[m_pos] = d;
            m_pos++;
            if (m_pos == LANES) begin
               for (int i = 0; i < LANES; i++) m_lanes[i*W +: W] = m_beats[i];
               exp_valid = 1;
               m_cnt = m_cnt + 8'd1;
               m_pos = -1;
            end
         end
      end
      exp_slot = (m_pos < 0) ? 2'd0 : 2'(m_pos);
   endtask

   // Drive one cycle, advance the model, then leave time for outputs to settle.
   task automatic step(input logic v, input logic s, input logic [W-1:0] d);
      @(negedge clk);
      in_valid = v; in_sof = s; in_data = d;
      @(posedge clk);
      model_beat(v, s, d);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1, 1, 2'b01); step(1, 0, 2'b10); step(1, 0, 2'b11);
      @(negedge clk);
      in_valid = 0; rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if (out_lanes !== 8'h00 || out_valid !== 1'b0 || err !== 1'b0 || slot !== 2'd0 || frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: lanes=%h valid=%b err=%b slot=%0d cnt=%0d required all zero",
                  out_lanes, out_valid, err, slot, frame_cnt);
      end
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 2'b11);
         checks++;
         if (out_lanes !== m_lanes || out_valid !== exp_valid || err !== exp_err || slot !== exp_slot || frame_cnt !== m_cnt) begin
            errors++;
            $display("FAIL reset_stray[%0d]: lanes=%h/%h valid=%b/%b err=%b/%b slot=%0d/%0d cnt=%0d/%0d",
                     i, out_lanes, m_lanes, out_valid, exp_valid, err, exp_err, slot, exp_slot, frame_cnt, m_cnt);
         end
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] d [4];
      d[0] = 2'b01; d[1] = 2'b10; d[2] = 2'b11; d[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         step(1, i == 0, d[i]);
         checks++;
         if (out_lanes !== m_lanes || out_valid !== exp_valid || err !== exp_err || slot !== exp_slot || frame_cnt !== m_cnt) begin
            errors++;
            $display("FAIL basic[%0d]: lanes=%h/%h valid=%b/%b err=%b/%b slot=%0d/%0d cnt=%0d/%0d",
                     i, out_lanes, m_lanes, out_valid, exp_valid, err, exp_err, slot, exp_slot, frame_cnt, m_cnt);
         end
      end
      checks++;
      if (out_lanes !== 8'h39 || out_valid !== 1'b1 || frame_cnt !== 8'd1) begin
         errors++;
         $display("FAIL basic_word: lanes=%h valid=%b cnt=%0d required 39/1/1", out_lanes, out_valid, frame_cnt);
      end
      step(0, 0, 2'b00);
      checks++;
      if (out_valid !== 1'b0 || out_lanes !== 8'h39) begin
         errors++;
         $display("FAIL basic_pulse: valid=%b lanes=%h required 0/39", out_valid, out_lanes);
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] d [4];
      int pulses = 0;
      d[0] = 2'b01; d[1] = 2'b10; d[2] = 2'b11; d[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 4; g++) begin
            if (g == 0) step(1, i == 0, d[i]);
            else step(0, $urandom_range(0, 1), 2'($urandom));
            if (out_valid) pulses++;
            checks++;
            if (out_lanes !== m_lanes || out_valid !== exp_valid || err !== exp_err || slot !== exp_slot || frame_cnt !== m_cnt) begin
               errors++;
               $display("FAIL gaps[%0d.%0d]: lanes=%h/%h valid=%b/%b err=%b/%b slot=%0d/%0d cnt=%0d/%0d",
                        i, g, out_lanes, m_lanes, out_valid, exp_valid, err, exp_err, slot, exp_slot, frame_cnt, m_cnt);
            end
         end
      end
      checks++;
      if (pulses != 1 || out_lanes !== 8'h39) begin
         errors++;
         $display("FAIL gaps_summary: pulses=%0d lanes=%h required 1/39", pulses, out_lanes);
      end
   endtask

   task automatic test_resync();
      logic       s [6];
      logic [W-1:0] d [6];
      int errs = 0, pulses = 0;
      s = '{1, 0, 1, 0, 0, 0};
      d = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
      for (int i = 0; i < 6; i++) begin
         step(1, s[i], d[i]);
         if (err) errs++;
         if (out_valid) pulses++;
         checks++;
         if (out_lanes !== m_lanes || out_valid !== exp_valid || err !== exp_err || slot !== exp_slot || frame_cnt !== m_cnt) begin
            errors++;
            $display("FAIL resync[%0d]: lanes=%h/%h valid=%b/%b err=%b/%b slot=%0d/%0d cnt=%0d/%0d",
                     i, out_lanes, m_lanes, out_valid, exp_valid, err, exp_err, slot, exp_slot, frame_cnt, m_cnt);
         end
         if (i < 5) begin
            checks++;
            if (out_lanes !== 8'h39) begin
               errors++;
               $display("FAIL resync_hold[%0d]: lanes=%h required 39", i, out_lanes);
            end
         end
      end
      checks++;
      if (out_lanes !== 8'h93 || errs != 1 || pulses != 1) begin
         errors++;
         $display("FAIL resync_summary: lanes=%h errs=%0d pulses=%0d required 93/1/1", out_lanes, errs, pulses);
      end
   endtask

   task automatic test_stream();
      int pulses = 0, bad_spacing = 0, last = -1, cyc = 0;
      @(negedge clk); in_valid = 0; rst = 1'b0;
      #1; model_reset();
      @(negedge clk); rst = 1'b1;
      for (int f = 0; f < 256; f++) begin
         for (int b = 0; b < LANES; b++) begin
            step(1, b == 0, 2'($urandom));
            cyc++;
            if (out_valid) begin
               if (last >= 0 && cyc - last != LANES) bad_spacing++;
               last = cyc; pulses++;
            end
            checks++;
            if (out_lanes !== m_lanes || out_valid !== exp_valid || err !== exp_err || slot !== exp_slot || frame_cnt !== m_cnt) begin
               errors++;
               $display("FAIL stream[%0d.%0d]: lanes=%h/%h valid=%b/%b err=%b/%b slot=%0d/%0d cnt=%0d/%0d",
                        f, b, out_lanes, m_lanes, out_valid, exp_valid, err, exp_err, slot, exp_slot, frame_cnt, m_cnt);
            end
         end
      end
      checks++;
      if (pulses != 256 || bad_spacing != 0 || frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL stream_wrap: pulses=%0d spacing_errs=%0d cnt=%0d required 256/0/0",
                  pulses, bad_spacing, frame_cnt);
      end
   endtask

   task automatic test_random();
      logic [7:0] held;
      for (int i = 0; i < 2000; i++) begin
         logic v, s;
         v = ($urandom_range(0, 3) != 0);
         s = (m_pos < 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         held = m_lanes;
         step(v, s, 2'($urandom));
         checks++;
         if (out_lanes !== m_lanes || out_valid !== exp_valid || err !== exp_err || slot !== exp_slot || frame_cnt !== m_cnt) begin
            errors++;
            $display("FAIL random[%0d]: lanes=%h/%h valid=%b/%b err=%b/%b slot=%0d/%0d cnt=%0d/%0d",
                     i, out_lanes, m_lanes, out_valid, exp_valid, err, exp_err, slot, exp_slot, frame_cnt, m_cnt);
         end
         if (!exp_valid && out_lanes !== held) begin
            errors++;
            $display("FAIL random_hold[%0d]: lanes=%h required %h", i, out_lanes, held);
         end
         if (out_valid && err) begin
            errors++;
            $display("FAIL random_excl[%0d]: valid=1 err=1 required not both", i);
         end
      end
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < LANES; i++) m_beats[i] = '0;
      test_reset();
      test_basic();
      test_gaps();
      test_resync();
      test_stream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/tdm_lane_demux.md
# tdm_lane_demux

Receive-side counterpart of the board's 4:1 lane selector. It takes a time-multiplexed stream of W-bit beats, one lane per beat and framed by a start-of-frame marker, and distributes the beats into LANES parallel registers. The lane word is published atomically, with a one-cycle valid pulse, once a complete frame has arrived. It sits between a serial lane source (switch/PS2-driven test logic) and parallel consumers (LEDs, seven-segment decoders).

## Interface
- W, default 2: bits per lane/beat.
- LANES, default 4: lanes per frame; power of two, ≥2. SW = $clog2(LANES).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  qualifies a beat as lane 0 of a new frame; ignored when in_valid=0.
- in_data  input  W  beat payload.
- out_lanes  output  LANES*W  last complete frame; lane i at [i*W +: W].
- out_valid  output  1  one-cycle pulse: out_lanes was just updated.
- err  output  1  one-cycle pulse: frame aborted by an early in_sof.
- slot  output  SW  index the next non-SOF beat will fill (0 in IDLE).
- frame_cnt  output  8  completed frames, wraps 255→0.

## Operation
- State machine: IDLE, COLLECT.
- Accepted beat = in_valid=1 at a rising edge. Cycles with in_valid=0 change nothing; gaps are unlimited and there is no timeout.
- IDLE:
  - Beat with in_sof=0: dropped silently, no err.
  - Beat with in_sof=1: shadow[0]←in_data, slot←1, go COLLECT.
- COLLECT, beat with in_sof=0:
  - shadow[slot]←in_data.
  - If slot<LANES-1: slot←slot+1.
  - If slot=LANES-1: out_lanes←{in_data, shadow[LANES-2:0]} in one edge, out_valid←1, frame_cnt←frame_cnt+1, slot←0, go IDLE.
- COLLECT, beat with in_sof=1: err←1, partial frame discarded, out_lanes untouched. The beat starts a new frame: shadow[0]←in_data, slot←1, stay COLLECT.
- Shadow registers are internal. out_lanes changes only on frame completion and holds between frames.
- Simultaneous in_sof=1 and the final-lane position: handled as resync (err), not completion.
- Resulting frame length: one SOF beat plus exactly LANES-1 non-SOF beats.

## Timing
- Reset values (rst=0, immediate, independent of clk): state IDLE, slot 0, out_lanes 0, out_valid 0, err 0, frame_cnt 0, shadows 0.
- Reset mid-frame discards the partial frame. The first edge after rst rises behaves as IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: out_lanes/out_valid become visible in the cycle after the edge that accepts the final beat.
- out_valid is high exactly one cycle per completed frame. err is high exactly one cycle per aborted frame. They are never both high.
- Back-to-back frames: an SOF beat in the cycle right after the final beat is accepted (state is IDLE). Maximum throughput is one frame per LANES cycles, with out_valid pulsing every LANES cycles.
- There is no backpressure: the block accepts every beat.

## Test plan
- Reset: drive rst=0 after SOF plus 2 beats, then release → all outputs 0 and slot=0. Then beats 2'b11 (no SOF) ×4 → no out_valid.
- Basic frame, W=2/LANES=4: SOF 2'b01, then 2'b10, 2'b11, 2'b00 on consecutive cycles → out_lanes=8'h39 one cycle after the 4th beat, out_valid high for 1 cycle, frame_cnt=1.
- Gaps: same four beats with 3 idle cycles between each → identical out_lanes=8'h39, a single out_valid pulse, slot steps 1,2,3,0.
- Resync: complete a frame of 8'h39, then send SOF 2'b10, 2'b01, then SOF 2'b11, 2'b00, 2'b01, 2'b10 → err pulses once, out_lanes stays 8'h39 until the second frame completes, then becomes 8'h93, with no out_valid for the aborted frame.
- Streaming and wrap: 256 back-to-back frames with no idle cycles → out_valid every 4th cycle, frame_cnt returns to 0. Stray non-SOF beats inserted in IDLE are ignored and leave out_lanes unchanged.
